// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory side plus decode/controller handshake.
interface fetch_stage_if #(
    parameter int unsigned XLEN = riscv_fetch_pkg::XLEN_DEF
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            instr_valid;
    logic            instr_ready;
    logic            PCSrc;
    logic [XLEN-1:0] pc_target;
    logic            misalign_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        output instr, pc, pc_plus4, instr_valid, misalign_fault,
        input  instr_ready, PCSrc, pc_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        input  instr, pc, pc_plus4, instr_valid, misalign_fault,
        output instr_ready, PCSrc, pc_target
    );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Next-PC select (sequential or redirect) and redirect alignment check.
module pc_next
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misaligned_o
);

    // Sequential path wraps naturally modulo 2^XLEN.
    assign next_pc_o    = pc_src_i ? pc_target_i : pc_i + XLEN'(4);
    assign misaligned_o = pc_src_i && (pc_target_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, valid/ready to decode.
// Optional FETCH_PERF_CNT_EN adds retired_cnt / redirect_cnt outputs.
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | imem_req pulse, imem_addr = pc
// WAIT  | waiting for imem_rvalid (no timeout)
// HOLD  | instr_valid, waiting for instr_ready
// FAULT | misaligned redirect taken; parked until reset
module fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic clk,
    input  logic reset_n,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic            fault_q;

    logic [XLEN-1:0] pc_d;
    logic            misaligned;
    logic            accept;

    assign accept = (state_q == HOLD) && bus.instr_ready;

    pc_next #(
        .XLEN(XLEN)
    ) u_pc_next (
        .pc_i        (pc_q),
        .pc_src_i    (bus.PCSrc),
        .pc_target_i (bus.pc_target),
        .next_pc_o   (pc_d),
        .misaligned_o(misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    state_q <= WAIT;
                    req_q   <= 1'b0;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        // instr falls back to NOP whenever nothing valid is presented
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        if (misaligned) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
            endcase
        end
    end

    assign bus.imem_req       = req_q;
    assign bus.imem_addr      = pc_q;
    assign bus.instr          = instr_q;
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_q + XLEN'(4);
    assign bus.instr_valid    = valid_q;
    assign bus.misalign_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] redirect_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q  <= '0;
            redirect_q <= '0;
        end else if (accept) begin
            retired_q <= retired_q + 32'd1;
            if (bus.PCSrc && !misaligned) begin
                redirect_q <= redirect_q + 32'd1;
            end
        end
    end

    assign retired_cnt  = retired_q;
    assign redirect_cnt = redirect_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized fetch traffic.
module tb_fetch_stage;
    import riscv_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] redirect_cnt;
`endif

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .redirect_cnt(redirect_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: architectural PC and retire/redirect tallies.
    logic [31:0] exp_pc;
    int          exp_retired;
    int          exp_redirect;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_counters();
`ifdef FETCH_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, 32'(exp_retired));
        chk("redirect_cnt", redirect_cnt, 32'(exp_redirect));
`endif
    endtask

    task automatic do_reset(input bit late_rsp);
        reset_n          = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.PCSrc        = 1'b0;
        bus.pc_target    = 32'h0;
        @(negedge clk);
        exp_pc       = 32'h0000_0000;
        exp_retired  = 0;
        exp_redirect = 0;
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_fault", bus.misalign_fault, 1'b0);
        chk("rst_instr", bus.instr, NOP_INSTR);
        chk("rst_pc", bus.pc, exp_pc);
        chk_counters();
        if (late_rsp) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Entry: at the negedge of the expected REQ cycle. Exit: negedge after accept.
    task automatic fetch_one(input int lat, input int hold, input bit src,
                             input logic [31:0] tgt, input logic [31:0] data, input bit spur);
        logic [31:0] pc_at_fetch;
        pc_at_fetch = exp_pc;
        chk("req", bus.imem_req, 1'b1);
        chk("req_addr", bus.imem_addr, exp_pc);
        bus.imem_rvalid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            chk("wait_req", bus.imem_req, 1'b0);
            chk("wait_valid", bus.instr_valid, 1'b0);
            chk("wait_instr", bus.instr, NOP_INSTR);
            if (k == lat) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = data;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            chk("hold_valid", bus.instr_valid, 1'b1);
            chk("hold_instr", bus.instr, data);
            chk("hold_pc", bus.pc, pc_at_fetch);
            chk("hold_pc4", bus.pc_plus4, pc_at_fetch + 32'd4);
            chk("hold_req", bus.imem_req, 1'b0);
            if (h < hold) begin
                bus.instr_ready = 1'b0;
                bus.PCSrc       = 1'($urandom_range(0, 1));
                bus.pc_target   = $urandom;
                if (spur && h == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = ~data;
                end
            end else begin
                bus.instr_ready = 1'b1;
                bus.PCSrc       = src;
                bus.pc_target   = tgt;
            end
        end
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'($urandom_range(0, 1));
        bus.pc_target   = $urandom;
        chk("post_valid", bus.instr_valid, 1'b0);
        chk("post_instr", bus.instr, NOP_INSTR);
        exp_retired++;
        if (src && tgt[1:0] != 2'b00) begin
            chk("fault_set", bus.misalign_fault, 1'b1);
            chk("fault_req", bus.imem_req, 1'b0);
        end else begin
            chk("no_fault", bus.misalign_fault, 1'b0);
            exp_pc = src ? tgt : exp_pc + 32'd4;
            if (src) exp_redirect++;
        end
        chk_counters();
    endtask

    task automatic fault_park(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_rvalid = 1'($urandom_range(0, 1));
            bus.imem_rdata  = $urandom;
            bus.instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("park_req", bus.imem_req, 1'b0);
            chk("park_valid", bus.instr_valid, 1'b0);
            chk("park_fault", bus.misalign_fault, 1'b1);
            chk("park_instr", bus.instr, NOP_INSTR);
        end
        bus.imem_rvalid = 1'b0;
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] tgt;
        int          hold;

        do_reset(1'b0);

        fetch_one(1, 0, 1'b0, 32'h0, 32'h0050_0093, 1'b0);
        fetch_one(1, 0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0);
        // Backpressure: last-cycle PCSrc wins over toggling during the stall.
        fetch_one(2, 5, 1'b1, 32'h0000_0100, 32'hCAFE_0001, 1'b0);
        fetch_one(4, 2, 1'b0, 32'h0000_0003, 32'hCAFE_0002, 1'b1);
        // PC wrap from the top of the address space.
        fetch_one(1, 0, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_0003, 1'b0);
        fetch_one(1, 1, 1'b0, 32'h0, 32'hCAFE_0004, 1'b1);
        chk("wrap_pc", exp_pc, 32'h0);

        for (int n = 0; n < 40; n++) begin
            tgt  = $urandom & 32'hFFFF_FFFC;
            hold = $urandom_range(0, 3);
            fetch_one($urandom_range(1, 4), hold, 1'($urandom_range(0, 1)), tgt, $urandom,
                      (hold > 0) && ($urandom_range(0, 1) == 1));
        end

        // Redirect to a known nonzero PC, then reset while waiting for memory.
        fetch_one(1, 0, 1'b1, 32'h0000_0200, 32'hCAFE_0005, 1'b0);
        chk("mid_req", bus.imem_req, 1'b1);
        chk("mid_addr", bus.imem_addr, 32'h0000_0200);
        @(negedge clk);
        chk("mid_wait_req", bus.imem_req, 1'b0);
        do_reset(1'b1);
        fetch_one(1, 0, 1'b0, 32'h0, 32'h0000_1111, 1'b0);

        fetch_one(1, 1, 1'b1, 32'h0000_0042, 32'h0000_2222, 1'b0);
        fault_park(10);

        do_reset(1'b0);
        fetch_one(1, 0, 1'b0, 32'h0, 32'h0000_3333, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the single-cycle RISC-V core; sits directly upstream of decode/controller.
- Owns the architectural PC and issues one request at a time to instruction memory. Latches the returned word and presents it with a valid/ready handshake.
- Consumes the controller's PCSrc together with the datapath target to select the next PC when an instruction retires.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  XLEN  fetch address; valid while imem_req=1.
- imem_rvalid  in  1  read data valid; earliest one cycle after imem_req.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction to decode/controller.
- pc  out  XLEN  PC of instr.
- pc_plus4  out  XLEN  pc+4, for JAL/JALR link.
- instr_valid  out  1  instr/pc are valid.
- instr_ready  in  1  downstream retires instr this cycle.
- PCSrc  in  1  from controller; 1 = take pc_target on retire.
- pc_target  in  XLEN  branch/jump target from datapath.
- misalign_fault  out  1  sticky; redirect target not 4-byte aligned.

Behaviour:
Reset values (async, reset_n=0):
- State IDLE, pc=RESET_PC.
- imem_req=0, instr_valid=0, misalign_fault=0.
- instr=32'h0000_0013 (NOP).

FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req=1, imem_addr=pc, for exactly one cycle, then WAIT.
- WAIT: on imem_rvalid, latch imem_rdata into instr and go to HOLD. No timeout; stays in WAIT indefinitely.
- HOLD: instr_valid=1; instr and pc remain stable until accept. Accept occurs when instr_ready=1 in HOLD.
  - Next PC = PCSrc ? pc_target : pc+4.
  - If PCSrc=1 and pc_target[1:0]!=0: go to FAULT, set misalign_fault=1, pc unchanged.
  - Otherwise load the new pc and go to REQ in the next cycle.
- FAULT: no requests, instr_valid=0; exit only via reset.

Timing and ordering:
- Minimum throughput is 3 cycles per instruction: REQ at t, rvalid at t+1, valid at t+2, accept at t+2, REQ at t+3.
- PCSrc and pc_target are sampled only in the accept cycle; ignored otherwise.
- imem_rvalid outside WAIT (spurious, or a late response after reset) is ignored.
- Only one request is outstanding; imem_req never asserts in WAIT or HOLD.
- instr_valid drops the cycle after accept.
- instr is driven with NOP whenever instr_valid=0.

Arithmetic:
- pc+4 is modulo 2^XLEN; wrap from 32'hFFFF_FFFC gives 0, which is legal with no fault.

Reset mid-operation:
- Immediate return to reset values regardless of state.
- An in-flight memory response is discarded.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs retired_cnt[31:0] and redirect_cnt[31:0].
  - retired_cnt increments on every accept.
  - redirect_cnt increments on accept with PCSrc=1 that does not fault.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package riscv_fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD, FAULT);
  - NOP_INSTR = 32'h0000_0013;
  - default XLEN and RESET_PC constants.
- Sub-module pc_next: combinational next-PC mux plus alignment check.
  - Inputs: pc, PCSrc, pc_target.
  - Outputs: next_pc, misaligned.

Test Plan:
1. Reset, then release; memory returns 32'h00500093 one cycle after req -> imem_addr=0 in REQ; instr_valid at cycle 3 with pc=0, pc_plus4=4; instr_ready=1 -> next imem_addr=4.
2. Taken branch: accept with PCSrc=1, pc_target=32'h0000_0040 -> next request addr 32'h40; pc=32'h40 on the next valid instruction; redirect_cnt=1 when FETCH_PERF_CNT_EN defined.
3. Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr/pc stable, no imem_req, PCSrc toggling ignored; accept on cycle 6 uses that cycle's PCSrc.
4. Misaligned target: accept with PCSrc=1, pc_target=32'h0000_0042 -> misalign_fault=1 next cycle, no further imem_req, instr_valid=0 until reset.
5. Memory latency 4 cycles and a spurious rvalid in HOLD -> instr unchanged by the spurious pulse; WAIT holds for all 4 cycles.
6. reset_n pulsed low during WAIT, response arrives after release -> late rvalid ignored, pc=RESET_PC, a fresh REQ to RESET_PC is issued after IDLE.
